// File: rtl/period_meter_pkg.sv
// Shared types and helpers for period_meter and its sync front end.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // ceil(log2(n)); elaboration-time only
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// 2-flop synchronizer plus delay flop with single-cycle rise/fall pulses.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= 3'b000;
    else     {s1, s2, s3} <= {d, s1, s2};
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
endmodule

// File: rtl/period_meter.sv
// Period (and optional high-time) meter for a slow asynchronous square wave.
// Optional high-time measurement: define PERIOD_METER_HIGH_TIME_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter  int MAX_PERIOD = 100000,
  localparam int W          = clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         slow_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout
);
  logic         level, rise, fall;
  logic [W-1:0] cnt;
  logic         at_max;
  logic         start, sample, expire, count;
  state_e       state, state_nxt;

  edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (slow_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign at_max = (cnt == W'(MAX_PERIOD));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (!rise && at_max) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    start  = 1'b0;
    sample = 1'b0;
    expire = 1'b0;
    count  = 1'b0;
    if (enable) begin
      case (state)
        ARM:     start = rise;
        MEASURE: begin
          sample = rise;
          expire = !rise && at_max;
          count  = !rise && !at_max;
        end
        default: ;
      endcase
    end
  end

  // cnt saturates into a timeout rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= sample;
      if (!enable || expire)   cnt <= '0;
      else if (start || sample) cnt <= W'(1);
      else if (count)          cnt <= cnt + 1'b1;
      if (sample) begin
        period  <= cnt;
        timeout <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [W-1:0] hcnt, hold;
  logic         hclr;

  // hcnt==0 marks "no rise seen yet", so a partial first high phase is ignored
  assign hclr = !enable || expire || (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      hold      <= '0;
      high_time <= '0;
    end else begin
      if (hclr) begin
        hcnt <= '0;
        hold <= '0;
      end else begin
        if (rise) hcnt <= W'(1);
        else if (level && hcnt != '0 && hcnt != W'(MAX_PERIOD)) hcnt <= hcnt + 1'b1;
        if (fall) hold <= hcnt;
      end
      if (sample) high_time <= hold;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{level, fall};
  assign high_time = '0;
`endif
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter (MAX_PERIOD=64): vector table, corner sequences, random model.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int MAXP = 64;
  localparam int W    = clog2(MAXP + 1);

  logic         clk = 1'b0;
  logic         rst, enable, slow_in;
  logic [W-1:0] period, high_time;
  logic         valid, timeout;

  period_meter #(.MAX_PERIOD(MAXP)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .slow_in  (slow_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // observation state, sampled 1ns after each rising edge
  int   vcount, last_vcyc, to_rises, to_rise_cyc, last_p;
  int   p_q[$], h_q[$], t_q[$];
  logic valid_d = 1'b0, to_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (valid) begin
      vcount++;
      last_vcyc = cyc;
      last_p    = int'(period);
      p_q.push_back(int'(period));
      h_q.push_back(int'(high_time));
      t_q.push_back(int'(timeout));
      chk("valid_one_cycle", {31'd0, valid_d}, 32'd0);
    end
    if (timeout && !to_d) begin
      to_rises++;
      to_rise_cyc = cyc;
    end
    valid_d = valid;
    to_d    = timeout;
  end

  function automatic int exp_h(input int h);
`ifdef PERIOD_METER_HIGH_TIME_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic clear_obs();
    p_q.delete(); h_q.delete(); t_q.delete();
    vcount = 0; to_rises = 0; last_p = -1;
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    slow_in = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic run_square(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic restart();
    rst = 1'b1; enable = 1'b1; slow_in = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(3);
    clear_obs();
  endtask

  typedef struct {
    int h;
    int l;
    int n;
    int exp_p;
  } vec_t;

  vec_t tbl[5];
  int   hs[40], ls[40];
  int   ep_q[$], eh_q[$];
  int   base, to_exp;
  bit   to_flag;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{h: 4,  l: 6,  n: 5, exp_p: 10};
    tbl[1] = '{h: 2,  l: 2,  n: 8, exp_p: 4};
    tbl[2] = '{h: 32, l: 32, n: 3, exp_p: 64};
    tbl[3] = '{h: 10, l: 10, n: 4, exp_p: 20};
    tbl[4] = '{h: 3,  l: 5,  n: 4, exp_p: 8};

    rst = 1'b1; enable = 1'b0; slow_in = 1'b0;
    clear_obs();

    // reset held with input toggling after a live measurement
    restart();
    run_square(4, 6, 3);
    idle(2);
    chk("pre_reset_period", 32'(period), 32'd10);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(i[0]);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_high", 32'(high_time), 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
    end
    rst = 1'b0; slow_in = 1'b0;
    idle(3);

    // table of steady square waves
    foreach (tbl[t]) begin
      restart();
      run_square(tbl[t].h, tbl[t].l, tbl[t].n);
      idle(6);
      chk("tbl_count", 32'(p_q.size()), 32'(tbl[t].n - 1));
      for (int i = 0; i < p_q.size(); i++) begin
        chk("tbl_period", 32'(p_q[i]), 32'(tbl[t].exp_p));
        chk("tbl_high", 32'(h_q[i]), 32'(exp_h(tbl[t].h)));
        chk("tbl_timeout", 32'(t_q[i]), 32'd0);
      end
    end

    // reset mid-period discards the partial count
    restart();
    run_square(4, 6, 2);
    for (int i = 0; i < 4; i++) step(1'b1);
    idle(2);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    idle(3);
    chk("midrst_period", 32'(period), 32'd0);
    base = vcount;
    run_square(4, 6, 1);
    chk("midrst_first_rise", 32'(vcount), 32'(base));
    run_square(4, 6, 1);
    idle(6);
    chk("midrst_second_rise", 32'(vcount), 32'(base + 1));
    chk("midrst_value", 32'(last_p), 32'd10);

    // stall after a 64-cycle wave, then recover with period 20
    restart();
    run_square(32, 32, 3);
    idle(100);
    chk("stall_valids", 32'(vcount), 32'd2);
    chk("stall_to_delay", 32'(to_rise_cyc - last_vcyc), 32'd64);
    chk("stall_sticky", {31'd0, timeout}, 32'd1);
    run_square(10, 10, 1);
    chk("recover_first_rise", 32'(vcount), 32'd2);
    chk("recover_to_held", {31'd0, timeout}, 32'd1);
    run_square(10, 10, 1);
    idle(6);
    chk("recover_valid", 32'(vcount), 32'd3);
    chk("recover_period", 32'(last_p), 32'd20);
    chk("recover_to_clr", {31'd0, timeout}, 32'd0);

    // period of MAX+1 never reports
    restart();
    run_square(10, 55, 4);
    idle(5);
    chk("p65_valids", 32'(vcount), 32'd0);
    chk("p65_timeout", {31'd0, timeout}, 32'd1);

    // enable dropped mid-period
    restart();
    run_square(4, 6, 3);
    for (int i = 0; i < 4; i++) step(1'b1);
    idle(2);
    base = vcount;
    enable = 1'b0;
    idle(3);
    chk("en_off_novalid", 32'(vcount), 32'(base));
    chk("en_off_hold", 32'(period), 32'd10);
    chk("en_off_hold_hi", 32'(high_time), 32'(exp_h(4)));
    enable = 1'b1;
    idle(1);
    run_square(4, 6, 1);
    chk("en_first_rise", 32'(vcount), 32'(base));
    run_square(4, 6, 2);
    idle(6);
    chk("en_two_more", 32'(vcount), 32'(base + 2));
    chk("en_period", 32'(last_p), 32'd10);

    // 2-high/2-low driven 3ns after the clock edge
    restart();
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #3 slow_in = (i < 2);
      end
    end
    idle(6);
    chk("async_count", 32'(p_q.size()), 32'd29);
    for (int i = 0; i < p_q.size(); i++) begin
      chk("async_period", 32'(p_q[i]), 32'd4);
      chk("async_high", 32'(h_q[i]), 32'(exp_h(2)));
    end

    // random phases against a rise-gap model
    restart();
    for (int i = 0; i < 40; i++) begin
      hs[i] = int'($urandom_range(2, 30));
      ls[i] = (i == 39) ? 6 : int'($urandom_range(2, 40));
    end
    ep_q.delete(); eh_q.delete();
    to_exp = 0; to_flag = 1'b0;
    for (int i = 1; i < 40; i++) begin
      if (hs[i-1] + ls[i-1] <= MAXP) begin
        ep_q.push_back(hs[i-1] + ls[i-1]);
        eh_q.push_back(exp_h(hs[i-1]));
        to_flag = 1'b0;
      end else if (!to_flag) begin
        to_exp++;
        to_flag = 1'b1;
      end
    end
    for (int i = 0; i < 40; i++) run_square(hs[i], ls[i], 1);
    idle(4);
    chk("rnd_count", 32'(p_q.size()), 32'(ep_q.size()));
    chk("rnd_to_events", 32'(to_rises), 32'(to_exp));
    for (int i = 0; i < p_q.size() && i < ep_q.size(); i++) begin
      chk("rnd_period", 32'(p_q[i]), 32'(ep_q[i]));
      chk("rnd_high", 32'(h_q[i]), 32'(eh_q[i]));
      chk("rnd_timeout", 32'(t_q[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
